// File: rtl/queue_pkg.sv
// Shared types and default sizing for the parametrised request queue.
package queue_pkg;

  typedef enum logic [1:0] {OP_NONE, OP_ENQ, OP_DEQ, OP_BOTH} queue_op_t;

  localparam int QUEUE_DATA_W = 8;
  localparam int QUEUE_DEPTH  = 8;

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector: rise_out is combinational from the input and the
// previous-cycle level, so a held level yields a single one-cycle event.
module rise_detect (
  input  logic clock_10KHZ,
  input  logic reset,
  input  logic sig_in,
  output logic rise_out
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = sig_in;
  end

  always_ff @(posedge clock_10KHZ or negedge reset) begin
    if (!reset) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign rise_out = sig_in & ~prev_q;

endmodule

// File: rtl/queue_fifo_param.sv
// Circular-buffer FIFO driven by edge-detected enqueue/dequeue levels; ops commit on
// the sampling edge, rejected requests set sticky overflow/underflow instead of stalling.
module queue_fifo_param
  import queue_pkg::*;
#(
  parameter int DATA_W = QUEUE_DATA_W,
  parameter int DEPTH  = QUEUE_DEPTH,
  parameter int LEN_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock_10KHZ,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              enqueue_in,
  input  logic              dequeue_in,
  input  logic              clear_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [LEN_W-1:0]  len_out,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic              enq_evt, deq_evt;
  queue_op_t         op;
  logic              wr_en;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  rise_detect u_enq_rise (
    .clock_10KHZ (clock_10KHZ),
    .reset       (reset),
    .sig_in      (enqueue_in),
    .rise_out    (enq_evt)
  );

  rise_detect u_deq_rise (
    .clock_10KHZ (clock_10KHZ),
    .reset       (reset),
    .sig_in      (dequeue_in),
    .rise_out    (deq_evt)
  );

  assign full  = (len_q == LEN_W'(DEPTH));
  assign empty = (len_q == '0);
  assign op    = queue_op_t'({deq_evt, enq_evt});

  always_comb begin
    wr_en        = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    len_d        = len_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    if (clear_in) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      len_d       = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      case (op)
        OP_ENQ: begin
          if (!full) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            len_d    = len_q + LEN_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        OP_DEQ: begin
          if (!empty) begin
            data_out_d   = mem_q[rd_ptr_q];
            data_valid_d = 1'b1;
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            len_d        = len_q - LEN_W'(1);
          end else begin
            underflow_d = 1'b1;
          end
        end
        OP_BOTH: begin
          // When full, wr_ptr equals rd_ptr: the old word is read before the write lands.
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (!empty) begin
            data_out_d   = mem_q[rd_ptr_q];
            data_valid_d = 1'b1;
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
          end else begin
            len_d       = len_q + LEN_W'(1);
            underflow_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_10KHZ or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      len_q        <= len_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  always_ff @(posedge clock_10KHZ) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign len_out    = len_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_queue_fifo_param.sv
// Directed and random stimulus for queue_fifo_param, checked against a queue-based model.
module tb_queue_fifo_param;

  localparam int DEPTH = 8;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       enqueue_in, dequeue_in, clear_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic [3:0] len_out;
  logic       full, empty, overflow, underflow;

  queue_fifo_param dut (
    .clock_10KHZ (clk),
    .reset       (reset),
    .data_in     (data_in),
    .enqueue_in  (enqueue_in),
    .dequeue_in  (dequeue_in),
    .clear_in    (clear_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .len_out     (len_out),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_dv, m_ov, m_un, m_enq_prev, m_deq_prev;

  task automatic model_reset();
    q.delete();
    m_dout = 8'h00; m_dv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    m_enq_prev = 1'b0; m_deq_prev = 1'b0;
  endtask

  task automatic cmp(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".data_out"},   int'(data_out),   int'(m_dout));
    cmp({tag, ".data_valid"}, int'(data_valid), int'(m_dv));
    cmp({tag, ".len_out"},    int'(len_out),    q.size());
    cmp({tag, ".full"},       int'(full),       int'(q.size() == DEPTH));
    cmp({tag, ".empty"},      int'(empty),      int'(q.size() == 0));
    cmp({tag, ".overflow"},   int'(overflow),   int'(m_ov));
    cmp({tag, ".underflow"},  int'(underflow),  int'(m_un));
  endtask

  // Drive levels, take one clock, advance the model by the same rules, compare.
  task automatic step(input logic e, input logic d, input logic c, input logic [7:0] din,
                      input string tag);
    logic ev_e, ev_d;
    enqueue_in = e; dequeue_in = d; clear_in = c; data_in = din;
    @(posedge clk);
    ev_e = e & ~m_enq_prev;
    ev_d = d & ~m_deq_prev;
    m_enq_prev = e;
    m_deq_prev = d;
    m_dv = 1'b0;
    if (c) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else if (ev_d) begin
      if (q.size() > 0) begin
        m_dout = q.pop_front();
        m_dv = 1'b1;
      end else begin
        m_un = 1'b1;
      end
      if (ev_e) q.push_back(din);
    end else if (ev_e) begin
      if (q.size() == DEPTH) m_ov = 1'b1;
      else q.push_back(din);
    end
    #1;
    check_all(tag);
  endtask

  task automatic enq_pulse(input logic [7:0] din, input string tag);
    step(1'b1, 1'b0, 1'b0, din, tag);
    step(1'b0, 1'b0, 1'b0, din, {tag, ".idle"});
  endtask

  task automatic deq_pulse(input string tag);
    step(1'b0, 1'b1, 1'b0, 8'h00, tag);
    step(1'b0, 1'b0, 1'b0, 8'h00, {tag, ".idle"});
  endtask

  initial begin
    reset = 1'b0; data_in = 8'h00;
    enqueue_in = 1'b0; dequeue_in = 1'b0; clear_in = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    #12 reset = 1'b1;

    // Basic order
    enq_pulse(8'h11, "enq11"); enq_pulse(8'h22, "enq22"); enq_pulse(8'h33, "enq33");
    for (int i = 0; i < 3; i++) deq_pulse("deq_basic");

    // Fill past full, drain, then wrap
    for (int i = 0; i < 9; i++) enq_pulse(8'(i), "fill");
    for (int i = 0; i < 8; i++) deq_pulse("drain");
    for (int i = 0; i < 4; i++) enq_pulse(8'(8'hC0 + i), "wrap_enq");
    for (int i = 0; i < 4; i++) deq_pulse("wrap_deq");

    // Underflow then clear
    deq_pulse("deq_empty");
    step(1'b0, 1'b0, 1'b1, 8'h00, "clear");
    step(1'b0, 1'b0, 1'b0, 8'h00, "after_clear");

    // Simultaneous enqueue and dequeue
    enq_pulse(8'hA0, "a0"); enq_pulse(8'hA1, "a1"); enq_pulse(8'hA2, "a2");
    step(1'b1, 1'b1, 1'b0, 8'hB0, "both");
    step(1'b0, 1'b0, 1'b0, 8'h00, "both.idle");
    for (int i = 0; i < 3; i++) deq_pulse("deq_after_both");

    // Both requests on a full queue, then both on an empty one
    for (int i = 0; i < 8; i++) enq_pulse(8'(8'hD0 + i), "fill2");
    step(1'b1, 1'b1, 1'b0, 8'hEE, "both_full");
    step(1'b0, 1'b0, 1'b1, 8'h00, "clear2");
    step(1'b1, 1'b1, 1'b0, 8'h77, "both_empty");
    step(1'b0, 1'b0, 1'b1, 8'h00, "clear3");

    // Held enqueue
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 8'h5A, "hold");
    step(1'b0, 1'b0, 1'b0, 8'h00, "hold.release");

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0), 8'($urandom), "rand");

    // Asynchronous reset mid-stream at occupancy 5
    step(1'b0, 1'b0, 1'b1, 8'h00, "pre_rst_clear");
    for (int i = 0; i < 5; i++) enq_pulse(8'(8'h60 + i), "pre_rst");
    cmp("pre_rst.len", int'(len_out), 5);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b1;
    deq_pulse("post_rst_deq");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
